shift_xfer_ctrl: RTL and testbench
==================================

SHIFT_XFER_CTRL -- requirements
Module: shift_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the shift length in bits. Legal values are 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1. When 1, it shifts left: sout is the MSB and sin enters at the LSB. When 0, it shifts right: sout is the LSB and sin enters at the MSB.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock. All state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: transfer request, sampled in IDLE only.
REQ-006 The block SHALL have port tx_data, input, WIDTH bits: parallel word loaded when start is accepted.
REQ-007 The block SHALL have port sin, input, 1 bit: serial input, sampled every SHIFT cycle.
REQ-008 The block SHALL have port sout, output, 1 bit: serial output.
REQ-009 The block SHALL have port busy, output, 1 bit: high in SHIFT state.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking transfer completion.
REQ-011 The block SHALL have port rx_data, output, WIDTH bits: captured parallel word.
REQ-012 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed word.
REQ-013 The block SHALL have port rx_ready, input, 1 bit: consumer accepts rx_data.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky flag, set when an unconsumed word is overwritten.
REQ-015 The block SHALL have port ovr_clr, input, 1 bit: synchronous clear for overrun.

Function
REQ-016 The block SHALL use two states, IDLE and SHIFT, plus an internal WIDTH-bit shift register and a bit counter sized to count 0..WIDTH-1.
REQ-017 In IDLE, on an edge with start=1, the block SHALL load the shift register with tx_data, clear the counter and enter SHIFT.
REQ-018 start SHALL be ignored while in SHIFT; no queuing.
REQ-019 In SHIFT, sout SHALL combinationally equal the outgoing end bit of the shift register. In IDLE, sout SHALL be 0.
REQ-020 On each SHIFT edge, the block SHALL shift by one position, insert sin at the incoming end and increment the counter.
REQ-021 On the SHIFT edge where the counter equals WIDTH-1, the block SHALL:
  - return to IDLE,
  - write the final shifted value, including that cycle's sin, into rx_data,
  - set rx_valid=1,
  - assert done for exactly the next cycle.
REQ-022 Timing for a start accepted at edge T SHALL be:
  - busy is high for cycles T+1..T+WIDTH,
  - done and rx_valid rise after edge T+WIDTH,
  - sout presents WIDTH bits, one per cycle.
REQ-023 A start that is high while done is high SHALL be accepted, giving back-to-back transfers with one IDLE cycle between them.
REQ-024 rx_valid SHALL clear on an edge where rx_valid=1 and rx_ready=1 and no capture occurs. rx_data SHALL hold its value after the clear.
REQ-025 When capture and consume (rx_valid=1, rx_ready=1) fall on the same edge, rx_data SHALL take the new word, rx_valid SHALL stay 1 and overrun SHALL be unchanged.
REQ-026 When capture occurs with rx_valid=1 and rx_ready=0, rx_data SHALL be overwritten and overrun SHALL be set to 1.
REQ-027 overrun SHALL stay 1 until ovr_clr=1 at an edge. If a set and ovr_clr fall on the same edge, set SHALL win.
REQ-028 rx_ready SHALL be ignored while rx_valid=0.

Reset
REQ-029 While rst=1, and immediately on its assertion, the block SHALL force:
  - state = IDLE, counter = 0, shift register = 0,
  - sout = 0, busy = 0, done = 0, rx_data = 0, rx_valid = 0, overrun = 0.
REQ-030 A reset during SHIFT SHALL abandon the transfer with no capture and no done pulse. The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-031 With WIDTH=8, MSB_FIRST=1, sout looped to sin, and start=1 for one cycle with tx_data=8'hB2, the bench SHALL see sout = 1,0,1,1,0,0,1,0, busy high for 8 cycles, one done pulse and rx_data=8'hB2 with rx_valid=1.
REQ-032 With tx_data=8'h00 and sin driven 1,0,1,1,0,0,1,0 on the SHIFT cycles, the bench SHALL see rx_data=8'hB2 and sout=0 throughout.
REQ-033 With start pulsed again at shift cycle 3, the bench SHALL see that pulse ignored: exactly 8 busy cycles and one done.
REQ-034 With two transfers of 8'h5A then 8'hC3 and rx_ready=0, the bench SHALL see overrun=1 and rx_data=8'hC3. After ovr_clr=1, overrun=0; after rx_ready=1, rx_valid=0.
REQ-035 With rst=1 pulsed at shift cycle 4, the bench SHALL see all outputs 0 at once and no done. A following start with 8'hFF SHALL complete with rx_data=8'hFF under loopback.
REQ-036 With MSB_FIRST=0, tx_data=8'hB2 and loopback, the bench SHALL see sout = 0,1,0,0,1,1,0,1 and rx_data=8'hB2.

Source files
------------

// File: rtl/shift_xfer_ctrl.sv
// shift_xfer_ctrl: serial shift transfer controller with captured-word handshake and overrun flag
module shift_xfer_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             sin,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun,
    input  logic             ovr_clr
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             capture;

    // Next shift-register value, and whether this edge completes the word
    always_comb begin
        shifted = MSB_FIRST ? {sreg[WIDTH-2:0], sin} : {sin, sreg[WIDTH-1:1]};
        last    = cnt == CW'(WIDTH - 1);
        capture = (state == SHIFT) && last;
        sout    = (state == SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : 1'b0;
    end

    assign busy = state == SHIFT;

    // Transfer FSM plus receive-side capture, consume and sticky overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done <= capture;
            case (state)
                IDLE: if (start) begin
                    sreg  <= tx_data;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sreg <= shifted;
                    cnt  <= last ? '0 : cnt + 1'b1;
                    if (last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (capture) begin
                rx_data  <= shifted;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            // A fresh overwrite of an unconsumed word beats a same-edge clear
            overrun <= (capture && rx_valid && !rx_ready) ? 1'b1 : ovr_clr ? 1'b0 : overrun;
        end
    end
endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// tb_shift_xfer_ctrl: directed scoreboard bench for shift_xfer_ctrl (MSB-first and LSB-first instances)
module tb_shift_xfer_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data = '0;
    logic       loop = 1'b1;
    logic       sin_drv = 1'b0;
    logic       sin_a;
    logic       sout, busy, done, rx_valid, overrun;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic       ovr_clr = 1'b0;

    logic       start_b = 1'b0;
    logic [7:0] tx_b = '0;
    logic       sout_b, busy_b, done_b, rx_valid_b, overrun_b;
    logic [7:0] rx_data_b;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_w;

    always #5 clk = ~clk;

    assign sin_a = loop ? sout : sin_drv;

    shift_xfer_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .sin(sin_a),
        .sout(sout), .busy(busy), .done(done), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    shift_xfer_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b), .sin(sout_b),
        .sout(sout_b), .busy(busy_b), .done(done_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_ready(1'b1), .overrun(overrun_b), .ovr_clr(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one transfer on dut_a starting and ending at a falling edge
    task automatic xfer(input logic [7:0] d, input logic lp, input logic [7:0] sin_pat,
                        input int restart_at, input logic b2b);
        loop    = lp;
        start   = 1'b1;
        tx_data = d;
        sb.push_back(lp ? d : sin_pat);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk("busy", busy, 1);
            chk("done_low", done, 0);
            chk("sout", sout, lp ? d[7-i] : 1'b0);
            sin_drv = sin_pat[7-i];
            start   = (i == restart_at);
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_end", busy, 0);
        chk("done", done, 1);
        chk("rx_valid", rx_valid, 1);
        exp_w = sb.pop_front();
        chk("rx_data", rx_data, exp_w);
        if (!b2b) begin
            @(posedge clk);
            @(negedge clk);
            chk("done_once", done, 0);
            chk("busy_idle", busy, 0);
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sout", sout, 0);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_rxd", rx_data, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        rx_ready = 1'b1;
        xfer(8'hB2, 1'b1, 8'h00, -1, 1'b0);
        chk("consume_rxv", rx_valid, 0);
        chk("consume_hold", rx_data, 8'hB2);

        xfer(8'h00, 1'b0, 8'hB2, -1, 1'b0);
        xfer(8'h3C, 1'b1, 8'h00, 3, 1'b0);

        rx_ready = 1'b0;
        xfer(8'h5A, 1'b1, 8'h00, -1, 1'b1);
        chk("ovr_first", overrun, 0);
        xfer(8'hC3, 1'b1, 8'h00, -1, 1'b0);
        chk("ovr_set", overrun, 1);
        chk("ovr_rxd", rx_data, 8'hC3);
        ovr_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clr", overrun, 0);
        chk("rxv_kept", rx_valid, 1);
        rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rxv_clr", rx_valid, 0);
        chk("rxd_hold", rx_data, 8'hC3);

        loop    = 1'b1;
        start   = 1'b1;
        tx_data = 8'h55;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sout", sout, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rxd", rx_data, 0);
        chk("mid_rst_rxv", rx_valid, 0);
        chk("mid_rst_ovr", overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_done", done, 0);
        end
        xfer(8'hFF, 1'b1, 8'h00, -1, 1'b0);

        start_b = 1'b1;
        tx_b    = 8'hB2;
        sb.push_back(8'hB2);
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("lsb_busy", busy_b, 1);
            chk("lsb_sout", sout_b, tx_b[i]);
            @(posedge clk);
            @(negedge clk);
        end
        chk("lsb_done", done_b, 1);
        chk("lsb_rxv", rx_valid_b, 1);
        exp_w = sb.pop_front();
        chk("lsb_rxd", rx_data_b, exp_w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
